// File: rtl/tx_fc_gate.sv
// TX flow-control gate: stalls the user stream toward the framer while the link partner requests pause.
// Build option TX_FC_PKT_BOUNDARY_EN defers each pause to the next packet boundary (adds DRAIN state).
module tx_fc_gate #(
  parameter int DWIDTH        = 256,
  parameter int PAUSE_TIMEOUT = 4096,
  parameter int RESUME_DELAY  = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 tx_frame_clk,
  input  logic                 rst,
  input  logic                 remote_fc,
  input  logic [DWIDTH-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [DWIDTH-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 paused,
  output logic                 fc_timeout,
  output logic [CNT_WIDTH-1:0] pause_cnt
);

  localparam int TW = $clog2(PAUSE_TIMEOUT + 1);
  localparam int RW = (RESUME_DELAY > 0) ? $clog2(RESUME_DELAY + 1) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(PAUSE_TIMEOUT);
  localparam logic [RW-1:0] RLOAD = RW'(RESUME_DELAY);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PAUSED,
    ST_RESUME_WAIT
  } state_t;

  state_t        state;
  logic          fc_q;
  logic          gate_open;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign gate_open     = (state == ST_RUN) || (state == ST_DRAIN);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & gate_open;
  assign s_axis_tready = m_axis_tready & gate_open;

`ifdef TX_FC_PKT_BOUNDARY_EN
  logic xfer;
  logic in_pkt;

  assign xfer = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge tx_frame_clk) begin
    if (rst) begin
      in_pkt <= 1'b0;
    end else if (xfer) begin
      in_pkt <= ~s_axis_tlast;
    end
  end
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; a later assignment in the block overrides an earlier one.
  always_ff @(posedge tx_frame_clk) begin
    if (rst) begin
      state      <= ST_RUN;
      fc_q       <= 1'b0;
      paused     <= 1'b0;
      fc_timeout <= 1'b0;
      pause_cnt  <= '0;
      tcnt       <= '0;
      rcnt       <= '0;
    end else begin
      fc_q <= remote_fc;

      // Pause-duration timer runs in both closed states and saturates.
      if (!gate_open && tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == TMAX - 1'b1) fc_timeout <= 1'b1;
      end

      case (state)
        ST_RUN: begin
          if (fc_q) begin
`ifdef TX_FC_PKT_BOUNDARY_EN
            if (in_pkt || (xfer && !s_axis_tlast)) begin
              state <= ST_DRAIN;
            end else begin
              state     <= ST_PAUSED;
              paused    <= 1'b1;
              pause_cnt <= sat_inc(pause_cnt);
            end
`else
            state     <= ST_PAUSED;
            paused    <= 1'b1;
            pause_cnt <= sat_inc(pause_cnt);
`endif
          end
        end

`ifdef TX_FC_PKT_BOUNDARY_EN
        ST_DRAIN: begin
          if (!fc_q) begin
            state <= ST_RUN;
            tcnt  <= '0;
          end else if (xfer && s_axis_tlast) begin
            state     <= ST_PAUSED;
            paused    <= 1'b1;
            pause_cnt <= sat_inc(pause_cnt);
          end
        end
`endif

        ST_PAUSED: begin
          if (!fc_q) begin
            if (RESUME_DELAY == 0) begin
              state  <= ST_RUN;
              paused <= 1'b0;
              tcnt   <= '0;
            end else begin
              state <= ST_RESUME_WAIT;
              rcnt  <= RLOAD;
            end
          end
        end

        ST_RESUME_WAIT: begin
          if (fc_q) begin
            state <= ST_PAUSED;
          end else if (rcnt == RW'(1)) begin
            state  <= ST_RUN;
            paused <= 1'b0;
            tcnt   <= '0;
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end

        default: begin
          state  <= ST_RUN;
          paused <= 1'b0;
          tcnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/tx_fc_gate.md
Name: tx_fc_gate

Overview:
- TX-side consumer of the received remote flow-control state (remote_fc, already in the tx_frame_clk domain).
- Sits between the user TX stream and the TX framer.
- Stalls user frames while the link partner requests pause (FC_ON) and releases them after FC_OFF plus a programmable resume delay.
- Provides pause status, a sticky pause-timeout alarm and a pause-event counter.

Parameters:
- DWIDTH, 256, user data width; one beat = one frame payload.
- PAUSE_TIMEOUT, 4096, consecutive paused cycles before fc_timeout sets; must be ≥1.
- RESUME_DELAY, 4, cycles held closed after remote_fc falls; 0 = resume immediately.
- CNT_WIDTH, 16, width of pause_cnt.

Ports:
- tx_frame_clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- remote_fc  in  1  1 = partner requests pause.
- s_axis_tdata  in  DWIDTH  user beat.
- s_axis_tvalid  in  1  user beat valid.
- s_axis_tlast  in  1  last beat of user packet.
- s_axis_tready  out  1  user beat accepted when tvalid&tready.
- m_axis_tdata  out  DWIDTH  to framer.
- m_axis_tvalid  out  1  to framer.
- m_axis_tlast  out  1  to framer.
- m_axis_tready  in  1  framer ready.
- paused  out  1  gate closed (state PAUSED or RESUME_WAIT).
- fc_timeout  out  1  sticky: pause lasted ≥ PAUSE_TIMEOUT cycles.
- pause_cnt  out  CNT_WIDTH  number of pause entries, saturating.

Behaviour:
- Input register: remote_fc is registered into fc_q (1 cycle). The FSM uses only fc_q.
- Gate signal open = (state == RUN || state == DRAIN).
- Datapath is combinational, zero latency:
  - m_axis_tdata = s_axis_tdata; m_axis_tlast = s_axis_tlast.
  - m_axis_tvalid = s_axis_tvalid & open.
  - s_axis_tready = m_axis_tready & open.
  - No beat is dropped or duplicated; a beat transferring in the cycle the state changes completes normally.
- Reset values: state RUN, fc_q 0, paused 0, fc_timeout 0, pause_cnt 0, timers 0, in_pkt 0.
- in_pkt: set on a transfer with tlast=0; cleared on a transfer with tlast=1.
- FSM transitions (evaluated each cycle):
  - RUN, fc_q=1 → PAUSED (macro behaviour in Optional Feature). Otherwise stay in RUN.
  - DRAIN (macro builds only), gate open:
    - fc_q=0 → RUN.
    - transfer with tlast=1 → PAUSED.
    - If both occur in the same cycle, fc_q=0 wins → RUN.
  - PAUSED, gate closed:
    - fc_q=0 and RESUME_DELAY=0 → RUN.
    - fc_q=0 and RESUME_DELAY>0 → RESUME_WAIT, with rcnt loaded to RESUME_DELAY.
  - RESUME_WAIT, gate closed:
    - fc_q=1 → PAUSED; rcnt is discarded.
    - else rcnt decrements; when rcnt==1 → RUN.
    - Gate is therefore closed exactly RESUME_DELAY cycles after leaving PAUSED.
- pause_cnt: +1 on each RUN→PAUSED or DRAIN→PAUSED transition; saturates at all-ones. RESUME_WAIT→PAUSED does not count.
- Timeout timer tcnt:
  - Increments every cycle in PAUSED or RESUME_WAIT; saturates at PAUSE_TIMEOUT.
  - Cleared on entry to RUN.
  - fc_timeout sets the cycle tcnt reaches PAUSE_TIMEOUT; cleared only by rst.
- paused is a registered state decode, high in PAUSED and RESUME_WAIT.
- Reset mid-operation: next cycle state RUN and gate open, regardless of remote_fc. Pause, if still requested, re-enters 2 cycles later: 1 cycle to register fc_q, 1 cycle for the transition.
- remote_fc pulse of 1 cycle: still yields one PAUSED entry (≥1 cycle) plus RESUME_DELAY cycles of RESUME_WAIT.

Optional Feature:
- Macro TX_FC_PKT_BOUNDARY_EN.
- Defined: in RUN, when fc_q=1:
  - if in_pkt=1, or a non-last beat transfers that cycle → DRAIN;
  - otherwise → PAUSED.
  - Packets are never split by a pause.
- Undefined: DRAIN state and in_pkt logic are absent; RUN goes straight to PAUSED (beat-boundary pause, packets may be split across a pause).

Test Plan:
- Idle pause/resume: RESUME_DELAY=4, remote_fc 0→1 at cycle 10 → paused=1 and s_axis_tready=0 from cycle 12. remote_fc→0 at cycle 30 → tready returns at cycle 36; pause_cnt=1.
- Streaming backpressure: continuous tvalid, m_axis_tready=1, 100 beats with a 20-cycle pause in the middle → all 100 beats appear in order with no loss or duplication; m_axis_tvalid=0 throughout the pause.
- Timeout: PAUSE_TIMEOUT=16, remote_fc held high 40 cycles → fc_timeout rises 16 cycles after PAUSED entry and stays 1 after resume until rst.
- Re-pause during resume: remote_fc falls, then rises again 2 cycles into RESUME_WAIT → state returns to PAUSED; pause_cnt is unchanged; the gate stays closed throughout.
- Packet boundary (macro defined): 8-beat packet, remote_fc rises after beat 3 → beats 4–8 still pass; gate closes after the tlast beat. Macro undefined → gate closes within 2 cycles, mid-packet.
- Reset mid-pause with remote_fc=1 → after rst: paused=0, pause_cnt=0, fc_timeout=0; PAUSED re-entered 2 cycles after rst deasserts; pause_cnt=1.
